// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants for the instruction encoder:
// opcodes, fixed funct fields, the request-kind enumeration, the HALT word
// and the encoder FSM state type.
package rv_isa_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_JALR    = 3'b000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;

  // The all-zero word is an illegal RV32I instruction and marks end of program.
  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  typedef enum logic [3:0] {
    KIND_LW   = 4'd0,
    KIND_SW   = 4'd1,
    KIND_RT   = 4'd2,
    KIND_BT   = 4'd3,
    KIND_IT   = 4'd4,
    KIND_JAL  = 4'd5,
    KIND_JALR = 4'd6,
    KIND_LUI  = 4'd7,
    KIND_HALT = 4'd8
  } req_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: request kind plus register/immediate fields into a
// 32-bit RV32I word. All immediate bit-slicing lives here; fields a format
// does not use are left at zero. Unknown kinds produce the HALT word.
module instr_pack (
  input  logic [3:0]  kind,
  input  logic [2:0]  funct3,
  input  logic        sub,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word
);
  import rv_isa_pkg::*;

  // Select the instruction format for the requested kind and assemble its fields
  always_comb begin
    word = HALT_WORD;
    case (kind)
      KIND_LW:   word = {imm[11:0], rs1, F3_WORD, rd, OPC_LOAD};
      KIND_SW:   word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
      KIND_RT:   word = {(sub ? F7_SUB : F7_ZERO), rs2, rs1, funct3, rd, OPC_OP};
      KIND_BT:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
      KIND_IT:   word = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
      KIND_JAL:  word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      KIND_JALR: word = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};
      KIND_LUI:  word = {imm[31:12], rd, OPC_LUI};
      KIND_HALT: word = HALT_WORD;
      default:   word = HALT_WORD;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts one request at a time, encodes it and writes
// it to instruction memory at an incrementing word address. A session opens
// on start and closes on HALT or on address overflow (which writes HALT and
// raises err). The counter saturates, never wrapping within a session.
// Optional build macro ENC_CHECK_EN adds field-legality checks: an illegal
// request sets err, is not written, and leaves state and counter unchanged.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [2:0]        funct3,
  input  logic              sub,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import rv_isa_pkg::*;

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A = {ADDR_W{1'b1}};

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       packed_s;
  logic              reject_s;
  logic              overflow_s;

  instr_pack u_pack (
    .kind   (req_kind),
    .funct3 (funct3),
    .sub    (sub),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .imm    (imm),
    .word   (packed_s)
  );

  // A non-HALT request arriving at the last address cannot be stored and still leave room for HALT
  assign overflow_s = (cnt_q == LAST_A) && (req_kind != KIND_HALT);

`ifdef ENC_CHECK_EN
  function automatic logic alu_f3_ok(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b010, 3'b100, 3'b110, 3'b111: alu_f3_ok = 1'b1;
      default:                                alu_f3_ok = 1'b0;
    endcase
  endfunction

  function automatic logic br_f3_ok(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b100, 3'b101: br_f3_ok = 1'b1;
      default:                        br_f3_ok = 1'b0;
    endcase
  endfunction

  // Flag requests whose fields are not legal for their kind
  always_comb begin
    reject_s = 1'b0;
    case (req_kind)
      KIND_RT: reject_s = !alu_f3_ok(funct3) || (sub && (funct3 != 3'b000));
      KIND_IT: reject_s = !alu_f3_ok(funct3);
      KIND_BT: reject_s = !br_f3_ok(funct3) || imm[0];
      default: reject_s = 1'b0;
    endcase
  end
`else
  assign reject_s = 1'b0;
`endif

  // State register plus registered output strobes, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ACCEPT; else state_d = ST_IDLE;
      ST_ACCEPT: if (req_valid && !reject_s) state_d = ST_WRITE; else state_d = ST_ACCEPT;
      ST_WRITE:  if (halt_q) state_d = ST_DONE; else state_d = ST_ACCEPT;
      ST_DONE:   if (start) state_d = ST_ACCEPT; else state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered strobes line up with the state
  always_comb begin
    req_ready_d = 1'b0;
    mem_we_d    = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      ST_ACCEPT: begin req_ready_d = 1'b1; busy_d = 1'b1; end
      ST_WRITE:  begin mem_we_d    = 1'b1; busy_d = 1'b1; end
      ST_DONE:   done_d = 1'b1;
      default:   done_d = 1'b0;
    endcase
  end

  // Datapath next values: address counter, captured word, end-of-session and error flags
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    halt_d = halt_q;
    err_d  = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cnt_d  = BASE_A;
          halt_d = 1'b0;
          err_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q;
        end
      end
      ST_ACCEPT: begin
        if (!req_valid) begin
          word_d = word_q;
        end else if (reject_s) begin
          err_d  = 1'b1;
        end else if (overflow_s) begin
          word_d = HALT_WORD;
          halt_d = 1'b1;
          err_d  = 1'b1;
        end else begin
          word_d = packed_s;
          halt_d = (req_kind == KIND_HALT);
        end
      end
      ST_WRITE: begin
        if (cnt_q != LAST_A) cnt_d = cnt_q + ADDR_W'(1); else cnt_d = cnt_q;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= BASE_A;
      word_q <= 32'h0000_0000;
      halt_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
      halt_q <= halt_d;
      err_q  <= err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = cnt_q;
  assign mem_wdata = word_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: a default-width instance
// for encodings, session control and reset, and an ADDR_W=2 instance for
// address overflow. Expected words are hand-assembled RV32I encodings.
module tb_instr_encoder;
  import rv_isa_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, start_b, req_valid, sub;
  logic [3:0]  req_kind;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  logic        ready_a, we_a, busy_a, done_a, err_a;
  logic [9:0]  addr_a;
  logic [31:0] wdata_a;
  logic        ready_b, we_b, busy_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;

  instr_encoder u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .req_valid(req_valid), .req_ready(ready_a),
    .req_kind(req_kind), .funct3(funct3), .sub(sub), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  instr_encoder #(.ADDR_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .req_valid(req_valid), .req_ready(ready_b),
    .req_kind(req_kind), .funct3(funct3), .sub(sub), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  bit          use_b = 1'b0;
  logic        obs_ready, obs_we, obs_busy, obs_done, obs_err;
  logic [9:0]  obs_addr;
  logic [31:0] obs_wdata;
  assign obs_ready = use_b ? ready_b : ready_a;
  assign obs_we    = use_b ? we_b    : we_a;
  assign obs_busy  = use_b ? busy_b  : busy_a;
  assign obs_done  = use_b ? done_b  : done_a;
  assign obs_err   = use_b ? err_b   : err_a;
  assign obs_addr  = use_b ? {8'd0, addr_b} : addr_a;
  assign obs_wdata = use_b ? wdata_b : wdata_a;

  int   n_checks = 0;
  int   n_errs   = 0;
  int   exp_addr = 0;
  logic exp_err  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one request, wait for acceptance, then inspect the following cycle.
  task automatic send(input string tag, input logic [3:0] k, input logic [2:0] f3, input logic s,
                      input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] im, input logic [31:0] exp_word, input bit exp_write);
    int n;
    @(negedge clk);
    req_kind = k; funct3 = f3; sub = s; rd = d; rs1 = r1; rs2 = r2; imm = im;
    req_valid = 1'b1;
    n = 0;
    while (!obs_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, {31'd0, obs_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_write) begin
      check({tag, "_we"},    {31'd0, obs_we},    32'd1);
      check({tag, "_addr"},  {22'd0, obs_addr},  exp_addr);
      check({tag, "_wdata"}, obs_wdata,          exp_word);
      check({tag, "_ready_in_write"}, {31'd0, obs_ready}, 32'd0);
      exp_addr++;
    end else begin
      check({tag, "_no_we"}, {31'd0, obs_we},    32'd0);
      check({tag, "_err"},   {31'd0, obs_err},   32'd1);
      check({tag, "_still_ready"}, {31'd0, obs_ready}, 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    {31'd0, obs_we},    32'd0);
    check({tag, "_ready"}, {31'd0, obs_ready}, 32'd0);
    check({tag, "_busy"},  {31'd0, obs_busy},  32'd0);
    check({tag, "_done"},  {31'd0, obs_done},  32'd0);
    check({tag, "_err"},   {31'd0, obs_err},   32'd0);
    check({tag, "_wdata"}, obs_wdata,          32'd0);
    check({tag, "_addr"},  {22'd0, obs_addr},  32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; req_valid = 1'b0; sub = 1'b0;
    req_kind = 4'd0; funct3 = 3'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Open a session on the default-width instance
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("start_ready", {31'd0, obs_ready}, 32'd1);
    check("start_busy",  {31'd0, obs_busy},  32'd1);

    send("rt",   KIND_RT,   3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3, 1'b1);
    send("lw",   KIND_LW,   3'b000, 1'b0, 5'd5, 5'd2, 5'd4, 32'd8,          32'h00812283, 1'b1);
    send("bt",   KIND_BT,   3'b000, 1'b0, 5'd7, 5'd1, 5'd2, 32'hFFFF_FFFC,  32'hFE208EE3, 1'b1);
    send("sw",   KIND_SW,   3'b000, 1'b0, 5'd9, 5'd2, 5'd5, 32'd12,         32'h00512623, 1'b1);
    send("sub",  KIND_RT,   3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,          32'h402081B3, 1'b1);
    send("jal",  KIND_JAL,  3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,          32'h008000EF, 1'b1);
    send("jalr", KIND_JALR, 3'b101, 1'b0, 5'd0, 5'd1, 5'd7, 32'd0,          32'h00008067, 1'b1);
    send("it",   KIND_IT,   3'b000, 1'b0, 5'd1, 5'd1, 5'd9, 32'hFFFF_FFFF,  32'hFFF08093, 1'b1);
    send("lui",  KIND_LUI,  3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1234_5000,  32'h123450B7, 1'b1);
`ifdef ENC_CHECK_EN
    send("bad_bt", KIND_BT, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,  32'h0, 1'b0);
    exp_err = 1'b1;
    send("after_bad", KIND_IT, 3'b000, 1'b0, 5'd1, 5'd1, 5'd0, 32'hFFFF_FFFF, 32'hFFF08093, 1'b1);
`endif
    send("halt", KIND_HALT, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0,          32'h00000000, 1'b1);
    @(negedge clk);
    check("halt_done",  {31'd0, obs_done},  32'd1);
    check("halt_ready", {31'd0, obs_ready}, 32'd0);
    check("halt_busy",  {31'd0, obs_busy},  32'd0);
    check("halt_err",   {31'd0, obs_err},   {31'd0, exp_err});

    // Restart from DONE, then reset in the middle of a write
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("restart_addr", {22'd0, obs_addr}, 32'd0);
    check("restart_done", {31'd0, obs_done}, 32'd0);
    check("restart_busy", {31'd0, obs_busy}, 32'd1);
    req_kind = KIND_RT; funct3 = 3'b000; sub = 1'b0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = 32'd0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstw_we_before", {31'd0, obs_we}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rstw");
    rst_n = 1'b1;

    // Overflow on the narrow instance
    use_b = 1'b1;
    exp_addr = 0;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int i = 0; i < 3; i++)
      send("ovf_fill", KIND_RT, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b1);
    send("ovf_last", KIND_RT, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h00000000, 1'b1);
    @(negedge clk);
    check("ovf_err",   {31'd0, obs_err},   32'd1);
    check("ovf_done",  {31'd0, obs_done},  32'd1);
    check("ovf_ready", {31'd0, obs_ready}, 32'd0);
    check("ovf_addr_sat", {22'd0, obs_addr}, 32'd3);
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    check("ovf_restart_addr", {22'd0, obs_addr}, 32'd0);
    check("ovf_restart_err",  {31'd0, obs_err},  32'd0);
    check("ovf_restart_done", {31'd0, obs_done}, 32'd0);
    exp_addr = 0;
    send("ovf_again", KIND_LW, 3'b000, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8, 32'h00812283, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
